// File: rtl/dpram_pingpong_ctrl.sv
// Ping-pong controller for a dual-port RAM split into two banks.
// The writer fills one bank through port A while the reader drains the other
// bank through port B into a small output FIFO with valid/ready handshaking.
module dpram_pingpong_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int FRAME_LEN  = 512
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic [DATA_WIDTH-1:0] ram_data_a,
  output logic [ADDR_WIDTH-1:0] ram_addr_a,
  output logic                  ram_we_a,
  output logic [ADDR_WIDTH-1:0] ram_addr_b,
  output logic                  ram_we_b,
  output logic [DATA_WIDTH-1:0] ram_data_b,
  input  logic [DATA_WIDTH-1:0] ram_q_b,
  output logic [1:0]            bank_full
);

  localparam int CW = $clog2(FRAME_LEN);
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_t;

  bank_state_t           bank_st [2];
  logic                  en;
  logic                  wr_bank;
  logic                  rd_bank;
  logic [CW-1:0]         wcnt;
  logic [CW-1:0]         rcnt;
  logic                  accept;
  logic                  rd_en;
  logic                  pop;
  logic                  inflight;
  logic                  inflight_last;
  logic [2:0]            occupancy;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH-1:0] addr_b_q;
  logic [DATA_WIDTH-1:0] fifo_data [2];
  logic                  fifo_last [2];
  logic                  fifo_head;
  logic                  fifo_tail;
  logic [1:0]            fifo_count;

  // Write side: accept into the current write bank while it is not yet full.
  always_comb begin
    in_ready   = en & ((bank_st[wr_bank] == EMPTY) | (bank_st[wr_bank] == FILLING));
    accept     = in_valid & in_ready;
    ram_we_a   = accept;
    ram_data_a = in_data;
    ram_addr_a = '0;
    ram_addr_a[CW-1:0]       = wcnt;
    ram_addr_a[ADDR_WIDTH-1] = wr_bank;
  end

  // Read side: issue a read only if the FIFO can absorb it after this cycle's pop.
  always_comb begin
    out_valid = (fifo_count != 2'd0);
    pop       = out_valid & out_ready;
    occupancy = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
    rd_en     = ((bank_st[rd_bank] == FULL) | (bank_st[rd_bank] == DRAINING))
              & (occupancy < 3'd2);
    rd_addr   = '0;
    rd_addr[CW-1:0]       = rcnt;
    rd_addr[ADDR_WIDTH-1] = rd_bank;
    ram_addr_b = rd_en ? rd_addr : addr_b_q;
  end

  // Output stream and status taken from the FIFO head and bank states.
  always_comb begin
    out_data     = fifo_data[fifo_head];
    out_last     = out_valid & fifo_last[fifo_head];
    bank_full[0] = (bank_st[0] == FULL) | (bank_st[0] == DRAINING);
    bank_full[1] = (bank_st[1] == FULL) | (bank_st[1] == DRAINING);
    ram_we_b     = 1'b0;
    ram_data_b   = '0;
  end

  // Bank state machine with write/read pointers and word counters.
  // Writer and reader always target different banks, so both updates can land on the same edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      en      <= 1'b0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wcnt    <= '0;
      rcnt    <= '0;
      for (int unsigned i = 0; i < 2; i++) bank_st[i] <= EMPTY;
    end else begin
      en <= 1'b1;
      if (accept) begin
        if (wcnt == LAST_IDX) begin
          bank_st[wr_bank] <= FULL;
          wcnt             <= '0;
          wr_bank          <= ~wr_bank;
        end else begin
          bank_st[wr_bank] <= FILLING;
          wcnt             <= wcnt + CW'(1);
        end
      end
      if (rd_en) begin
        if (rcnt == LAST_IDX) begin
          bank_st[rd_bank] <= EMPTY;
          rcnt             <= '0;
          rd_bank          <= ~rd_bank;
        end else begin
          bank_st[rd_bank] <= DRAINING;
          rcnt             <= rcnt + CW'(1);
        end
      end
    end
  end

  // Read pipeline: capture RAM data one cycle after the read into the 2-entry FIFO.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      addr_b_q      <= '0;
      fifo_head     <= 1'b0;
      fifo_tail     <= 1'b0;
      fifo_count    <= 2'd0;
      for (int unsigned i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_last[i] <= 1'b0;
      end
    end else begin
      inflight      <= rd_en;
      inflight_last <= rd_en & (rcnt == LAST_IDX);
      addr_b_q      <= ram_addr_b;
      if (inflight) begin
        fifo_data[fifo_tail] <= ram_q_b;
        fifo_last[fifo_tail] <= inflight_last;
        fifo_tail            <= ~fifo_tail;
      end
      if (pop) fifo_head <= ~fifo_head;
      fifo_count <= fifo_count + {1'b0, inflight} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_dpram_pingpong_ctrl.sv
// Scoreboard bench for dpram_pingpong_ctrl with a behavioural RAM model.
module tb_dpram_pingpong_ctrl;

  localparam int DW = 16;
  localparam int AW = 10;
  localparam int FL = 8;

  logic          clock;
  logic          reset_n;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic [DW-1:0] ram_data_a;
  logic [AW-1:0] ram_addr_a;
  logic          ram_we_a;
  logic [AW-1:0] ram_addr_b;
  logic          ram_we_b;
  logic [DW-1:0] ram_data_b;
  logic [DW-1:0] ram_q_b;
  logic [1:0]    bank_full;

  dpram_pingpong_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FRAME_LEN(FL)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .ram_data_a(ram_data_a), .ram_addr_a(ram_addr_a), .ram_we_a(ram_we_a),
    .ram_addr_b(ram_addr_b), .ram_we_b(ram_we_b), .ram_data_b(ram_data_b),
    .ram_q_b(ram_q_b), .bank_full(bank_full)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Dual-port RAM, registered read on port B
  logic [DW-1:0] mem [1 << AW];
  always @(posedge clock) begin
    if (ram_we_a) mem[ram_addr_a] <= ram_data_a;
    ram_q_b <= mem[ram_addr_b];
  end

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  exp_t q[$];
  int   pop_cycs[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   acc_cnt = 0;
  int   widx = 0;
  int   wbank = 0;
  logic          stall_prev = 1'b0;
  logic [DW-1:0] data_prev;
  logic          last_prev;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clock) cyc++;

  // Reference model: every accepted word is expected back in order, last on every FL-th word
  always @(negedge clock) begin
    if (reset_n) begin
      if (in_valid && in_ready) begin
        chk("we_a", 32'(ram_we_a), 32'd1);
        chk("addr_a", 32'(ram_addr_a), 32'(wbank * (1 << (AW - 1)) + widx));
        chk("data_a", 32'(ram_data_a), 32'(in_data));
        q.push_back('{data: in_data, last: (widx == FL - 1)});
        acc_cnt++;
        widx++;
        if (widx == FL) begin
          widx  = 0;
          wbank = 1 - wbank;
        end
      end else if (!in_valid) begin
        chk("we_a_idle", 32'(ram_we_a), 32'd0);
      end
    end
  end

  // Monitor: pop and compare on each output handshake, check stability while stalled
  always @(negedge clock) begin
    if (!reset_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", 32'(out_data), 32'(data_prev));
        chk("stall_last", 32'(out_last), 32'(last_prev));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("spurious_out", 32'(out_data), 32'hffff_ffff);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("out_data", 32'(out_data), 32'(e.data));
          chk("out_last", 32'(out_last), 32'(e.last));
          pop_cycs.push_back(cyc);
        end
      end
      stall_prev = out_valid && !out_ready;
      data_prev  = out_data;
      last_prev  = out_last;
    end
  end

  // Port-level invariants
  always @(negedge clock) begin
    if (reset_n) begin
      chk("we_b", 32'(ram_we_b), 32'd0);
      chk("data_b", 32'(ram_data_b), 32'd0);
      if (ram_we_a && dut.rd_en)
        chk("bank_conflict", 32'(ram_addr_a[AW-1] ^ ram_addr_b[AW-1]), 32'd1);
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_last"}, 32'(out_last), 32'd0);
    chk({tag, "_out_data"}, 32'(out_data), 32'd0);
    chk({tag, "_we_a"}, 32'(ram_we_a), 32'd0);
    chk({tag, "_addr_a"}, 32'(ram_addr_a), 32'd0);
    chk({tag, "_addr_b"}, 32'(ram_addr_b), 32'd0);
    chk({tag, "_bank_full"}, 32'(bank_full), 32'd0);
  endtask

  // Called at posedge+1; returns at posedge+1 after the word is accepted
  task automatic send(input logic [DW-1:0] d);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(negedge clock);
      if (in_ready) ok = 1'b1;
    end
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clock);
      done = (q.size() == 0) && !out_valid;
    end
    chk(name, 32'(done), 32'd1);
    @(posedge clock);
    #1;
  endtask

  initial begin
    int base;
    int c0;
    int guard;

    reset_n   = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_reset_vals("rst");

    // Reset release: in_ready rises on the first edge
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk("ready_before_edge", 32'(in_ready), 32'd0);
    @(posedge clock);
    #1;
    chk("ready_after_edge", 32'(in_ready), 32'd1);

    // Single frame 1..8 and its latency
    out_ready = 1'b1;
    for (int i = 1; i <= FL; i++) send(DW'(i));
    @(negedge clock);
    chk("lat_valid_e0", 32'(out_valid), 32'd0);
    chk("lat_bank_full", 32'(bank_full), 32'd1);
    @(negedge clock);
    chk("lat_valid_e1", 32'(out_valid), 32'd0);
    @(negedge clock);
    chk("lat_valid_e2", 32'(out_valid), 32'd1);
    wait_drain("drain_single");

    // Four back-to-back frames at full rate
    pop_cycs.delete();
    c0 = cyc;
    for (int i = 0; i < 4 * FL; i++) send(DW'(100 + i));
    chk("in_rate", 32'(cyc - c0), 32'(4 * FL));
    wait_drain("drain_cont");
    chk("out_count", 32'(pop_cycs.size()), 32'(4 * FL));
    if (pop_cycs.size() == 4 * FL)
      chk("out_rate", 32'(pop_cycs[4 * FL - 1] - pop_cycs[0]), 32'(4 * FL - 1));

    // Backpressure: both banks fill, FIFO holds two words
    out_ready = 1'b0;
    for (int i = 0; i < 2 * FL; i++) send(DW'(1000 + i));
    @(negedge clock);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_bank_full", 32'(bank_full), 32'd3);
    repeat (4) @(negedge clock);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    chk("bp_fifo_count", 32'(dut.fifo_count), 32'd2);
    chk("bp_in_ready_hold", 32'(in_ready), 32'd0);
    @(posedge clock);
    #1;
    out_ready = 1'b1;
    wait_drain("drain_bp");
    chk("bp_ready_after", 32'(in_ready), 32'd1);

    // Random traffic over 100 frames
    base  = acc_cnt;
    guard = 0;
    while (acc_cnt < base + 100 * FL && guard < 20000) begin
      in_valid  = 1'($urandom % 2);
      in_data   = DW'($urandom);
      out_ready = 1'($urandom % 2);
      @(posedge clock);
      #1;
      guard++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("rand_accepts", 32'(acc_cnt - base), 32'(100 * FL));
    wait_drain("drain_rand");

    // Reset in the middle of word 5 of the second frame
    out_ready = 1'b0;
    for (int i = 0; i < FL + 5; i++) send(DW'(3000 + i));
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_vals("mid");
    q.delete();
    widx  = 0;
    wbank = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b1;
    for (int i = 0; i < FL; i++) send(DW'(4000 + i));
    wait_drain("drain_after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dpram_pingpong_ctrl.md
# dpram_pingpong_ctrl

Double-buffer (ping-pong) controller for the team's dual-port RAM. It splits the RAM into two banks of 2**(ADDR_WIDTH-1) words. The writer stream fills one bank through port A while the reader stream drains the other bank through port B. Frames are fixed-length, and valid/ready backpressure is supported on both sides. The block sits between a sample producer and a frame consumer, and drives the RAM's port signals directly.

## Interface
- DATA_WIDTH, 16, word width; must match the RAM.
- ADDR_WIDTH, 10, RAM address width; the MSB selects the bank.
- FRAME_LEN, 512, words per frame; 2 ≤ FRAME_LEN ≤ 2**(ADDR_WIDTH-1).

Ports:
- clock  in  1  single clock; all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- in_data  in  DATA_WIDTH  write-stream word.
- in_valid  in  1  write-stream valid.
- in_ready  out  1  write-stream ready.
- out_data  out  DATA_WIDTH  read-stream word.
- out_valid  out  1  read-stream valid.
- out_ready  in  1  read-stream ready.
- out_last  out  1  high with the final word of each frame.
- ram_data_a  out  DATA_WIDTH  port A write data.
- ram_addr_a  out  ADDR_WIDTH  port A address.
- ram_we_a  out  1  port A write enable.
- ram_addr_b  out  ADDR_WIDTH  port B address.
- ram_we_b  out  1  port B write enable; tied 0.
- ram_data_b  out  DATA_WIDTH  port B write data; tied 0.
- ram_q_b  in  DATA_WIDTH  port B read data; registered, 1-cycle latency.
- bank_full  out  2  per-bank FULL-or-DRAINING status.

## Operation
- Each bank has a 2-bit state: EMPTY → FILLING → FULL → DRAINING → EMPTY.
- wr_bank and rd_bank are 1-bit pointers, both reset to 0.
- wcnt and rcnt are word counters, width clog2(FRAME_LEN), both reset to 0.

Write side:
- in_ready = en & (state[wr_bank] ∈ {EMPTY, FILLING}).
- en is a register: reset 0, set on the first clock edge after reset_n deasserts.
- Accept = in_valid & in_ready. On accept:
  - ram_we_a = 1, ram_addr_a = {wr_bank, wcnt}, ram_data_a = in_data (combinational pass-through).
  - The bank goes EMPTY→FILLING on its first word.
  - On the accept with wcnt == FRAME_LEN-1: the bank goes to FULL, wcnt returns to 0, wr_bank toggles.
- Outside an accept, ram_we_a = 0.

Read side:
- A 2-entry output FIFO holds read data.
- inflight is a 1-bit flag: a read was issued last cycle.
- rd_en = (state[rd_bank] ∈ {FULL, DRAINING}) & (fifo_count + inflight − (out_valid & out_ready) < 2).
- rd_en drives ram_addr_b = {rd_bank, rcnt}. When rd_en is low, ram_addr_b holds its last value.
- On rd_en: FULL→DRAINING, and rcnt increments.
- On rd_en with rcnt == FRAME_LEN-1: the bank goes to EMPTY at that edge, rcnt returns to 0, rd_bank toggles. Port A may then write the bank the following cycle, which is safe because the read address was already captured by the RAM.
- ram_q_b is pushed into the FIFO one cycle after rd_en. A per-entry last flag travels with the data and drives out_last.
- out_valid = FIFO non-empty; out_data and out_last come from the FIFO head.

Boundary conditions:
- Both banks FULL/DRAINING: in_ready = 0 until one bank returns to EMPTY.
- Both banks EMPTY: no reads are issued and out_valid = 0.
- Port A and port B never address the same bank in the same cycle.
- Reset mid-operation discards all partial and full frames. RAM contents are not cleared.

## Timing
Reset values:
- in_ready 0; out_valid 0; out_last 0; out_data 0.
- ram_we_a 0; ram_addr_a 0; ram_addr_b 0.
- bank_full 2'b00.
- All states EMPTY; all counters 0; FIFO empty.

Latency and throughput:
- Last word of a frame accepted at edge E: bank_full bit set after E; rd_en high in cycle E→E+1; out_valid high after E+2.
- With out_ready held at 1 and input continuous, both streams sustain 1 word/cycle with no bubbles, including across bank switches.
- The output stream follows valid/ready rules: out_data and out_last are stable while out_valid=1 & out_ready=0.

## Test plan
- Reset release: in_ready goes 0→1 on the first edge; push FRAME_LEN=8 words 1..8 with out_ready=1 → port A writes addresses 0..7; out_data = 1..8 starting 2 cycles after the 8th accept; out_last only with 8.
- Continuous stream of 4 frames with out_ready=1 → 32 words out in order; port A alternates bank 0/1 (addresses 0..7, 512..519); 1 word/cycle after initial latency.
- out_ready=0 with 2 frames pushed → in_ready drops after the 16th word; bank_full=2'b11; FIFO holds 2 words; out_data stable. Release out_ready → all 16 words, then in_ready=1.
- Random out_ready (50%) and random in_valid over 100 frames → scoreboard shows no loss, duplication or reorder, and out_last every 8th word.
- Assert reset_n low mid-frame (word 5 of frame 2) → all outputs return to reset values asynchronously; after release the next frame is read from bank 0 starting at word 0.
- Check ram_we_b = 0 always, and that ram_addr_a and ram_addr_b MSBs differ whenever ram_we_a=1 & rd_en=1.
